lsq_ctrl: RTL and testbench
===========================

# lsq_ctrl

In-order controller for the load/store queue. It owns a DEPTH-entry collapsing queue of 32-bit instruction words and accepts memory instructions from dispatch. It issues the head entry to the data-memory port through a valid/ready handshake, waits for load data, and then retires and shifts the queue. It sits between dispatch and the data-memory interface.

## Interface
Parameters:
- DEPTH, 8, number of queue slots; must be ≥2.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_async  in  1  asynchronous, active-high reset.
- reset_sync  in  1  synchronous flush; same clearing effect as reset, applied at the clock edge.
- disp_valid  in  1  dispatch offers an instruction.
- disp_instr  in  32  offered instruction word.
- disp_ready  out  1  queue can accept; equals !full.
- mem_req_valid  out  1  head instruction presented to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_instr  out  32  head word; 0 when mem_req_valid=0.
- mem_req_is_store  out  1  head opcode is store; 0 when not valid.
- mem_resp_valid  in  1  load data returned (1-cycle pulse).
- retire_valid  out  1  1-cycle pulse when the head retires.
- retire_instr  out  32  retired word; 0 when retire_valid=0.
- count  out  $clog2(DEPTH+1)  occupied slots.
- empty, full  out  1 each  count==0 / count==DEPTH.
- stall_cnt  out  16  dispatch-stall counter (see Configuration).

## Operation
- A slot holding 32'd0 is free, so an all-zero word is never enqueued. A handshake on a zero word is accepted (disp_ready honoured) and dropped.
- Push: disp_valid && disp_ready && disp_instr!=0 writes slot[count].
- Pop: the head retires and every slot shifts down by one; the last slot loads 0.
- When push and pop happen in the same cycle, the new word goes to slot[count-1] and count is unchanged.
- Opcode is disp_instr[31:27]: LW=5'b01000, SW=5'b00111. Any other opcode is treated as a load.
- FSM states and transitions:
  - IDLE: mem_req_valid=0. Go to REQ when count>0.
  - REQ: mem_req_valid=1, holding the head.
    - Store with mem_req_ready: pop and retire. Next state is REQ if the post-update count>0, otherwise IDLE.
    - Load with mem_req_ready: go to WAIT with no pop.
  - WAIT: mem_req_valid=0. On mem_resp_valid, pop and retire. Next state as in REQ.
- mem_resp_valid outside WAIT is ignored.
- While mem_req_valid=1, the request must not change until accepted; the head never moves while in REQ.
- Flush (reset_sync=1) has priority over push, pop and response:
  - All slots are cleared, count=0, state=IDLE, and no retire pulse is generated.
  - An outstanding load is abandoned; its late response is ignored.

## Timing
- Reset values: all slots 0, count=0, state IDLE, disp_ready=1, empty=1, full=0, mem_req_valid=0, retire_valid=0, stall_cnt=0.
- disp_ready, full, empty, count and mem_req_* are driven from registered state only. There is no combinational path from disp_valid or mem_req_ready.
- Latency, push into an empty queue to mem_req_valid: 2 cycles (edge 1 writes the slot, edge 2 enters REQ).
- Store throughput is 1 per cycle while mem_req_ready=1.
- Load retires on the edge where mem_resp_valid is sampled in WAIT. retire_valid is asserted the following cycle, registered.
- disp_ready does not anticipate a same-cycle pop: a full queue refuses dispatch even while retiring.

## Configuration
- LSQ_STALL_CNT_EN defined:
  - stall_cnt increments each cycle with disp_valid && !disp_ready.
  - It saturates at 16'hFFFF and is cleared by reset and by reset_sync.
- LSQ_STALL_CNT_EN undefined: stall_cnt is tied to 16'd0 and no counter flops exist.

## Structure
- Package lsq_pkg:
  - opcode constants OP_LW and OP_SW;
  - FSM state enum {IDLE, REQ, WAIT};
  - default DEPTH.
- Sub-module lsq_slot, one instance per slot:
  - a 32-bit register with load/shift select, sync clear and async clear;
  - a free output equal to the NOR of its contents.

## Test plan
- Reset, then push SW 0x38000004 with mem_req_ready=1: mem_req_valid rises 2 cycles later with is_store=1; retire_valid pulses with 0x38000004; count returns 0.
- Push LW 0x40000008, hold mem_req_ready=1, and delay mem_resp_valid by 5 cycles: state stays WAIT, count=1, and retire happens only after the response.
- Push DEPTH stores with mem_req_ready=0: full=1, disp_ready=0, and stall_cnt counts the refused cycles (0 when LSQ_STALL_CNT_EN is off). Then release ready: one retire per cycle.
- Push and pop in the same cycle at count=3: count stays 3, and FIFO order is preserved across 10 mixed ops.
- Pulse reset_sync while in WAIT, then send mem_resp_valid: no retire, count=0, state IDLE.
- Offer disp_instr=0: it is accepted with no count change and no issue.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue controller: opcodes, FSM states
// and the default queue depth.
package lsq_pkg;

  localparam int DEPTH_DEF = 8;

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsq_state_e;

  // Only SW is a store; every other opcode, LW included, behaves as a load.
  function automatic logic is_store_op(input logic [31:0] instr);
    return instr[31:27] == OP_SW;
  endfunction

endpackage

// File: rtl/lsq_slot.sv
// One queue slot: 32-bit register that either takes a dispatched word or the
// word from the slot above it. A zero word marks the slot as free.
module lsq_slot
  import lsq_pkg::*;
(
  input  logic        clock,
  input  logic        reset_async,
  input  logic        clear,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] load_data,
  input  logic [31:0] shift_data,
  output logic [31:0] q,
  output logic        free
);

  // Load wins over shift: on a simultaneous push/pop this slot receives the new word.
  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= shift_data;
    end
  end

  assign free = ~|q;

endmodule

// File: rtl/lsq_ctrl.sv
// In-order load/store queue controller: collapsing queue, memory request FSM
// and registered retire port. Define LSQ_STALL_CNT_EN to build the dispatch-stall counter.
module lsq_ctrl
  import lsq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset_async,
  input  logic                         reset_sync,
  input  logic                         disp_valid,
  input  logic [31:0]                  disp_instr,
  output logic                         disp_ready,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [31:0]                  mem_req_instr,
  output logic                         mem_req_is_store,
  input  logic                         mem_resp_valid,
  output logic                         retire_valid,
  output logic [31:0]                  retire_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic [15:0]                  stall_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]      slot_q   [DEPTH];
  logic [31:0]      shift_in [DEPTH];
  logic [DEPTH-1:0] slot_free;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx;
  lsq_state_e       state_q;
  lsq_state_e       state_d;
  logic             head_store;
  logic             push;
  logic             pop;
  logic             retire_vld_p1;
  logic [31:0]      retire_instr_p1;

  // Queue is collapsing, so occupancy status follows directly from the free flags.
  assign full       = ~|slot_free;
  assign empty      = &slot_free;
  assign disp_ready = ~full;
  assign head_store = is_store_op(slot_q[0]);

  assign push = disp_valid && disp_ready && (disp_instr != '0) && !reset_sync;
  assign pop  = !reset_sync &&
                (((state_q == REQ) && mem_req_ready && head_store) ||
                 ((state_q == WAIT) && mem_resp_valid));

  assign count_d = count_q + CW'(push) - CW'(pop);
  assign wr_idx  = count_q - CW'(pop);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == DEPTH - 1) begin : g_top
      assign shift_in[i] = '0;
    end else begin : g_mid
      assign shift_in[i] = slot_q[i+1];
    end

    lsq_slot u_slot (
      .clock       (clock),
      .reset_async (reset_async),
      .clear       (reset_sync),
      .load        (push && (wr_idx == CW'(i))),
      .shift       (pop),
      .load_data   (disp_instr),
      .shift_data  (shift_in[i]),
      .q           (slot_q[i]),
      .free        (slot_free[i])
    );
  end

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      count_q <= '0;
    end else if (reset_sync) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (reset_sync) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (count_q != '0) state_d = REQ;
        REQ: begin
          if (mem_req_ready) begin
            if (head_store) state_d = (count_d != '0) ? REQ : IDLE;
            else            state_d = WAIT;
          end
        end
        WAIT: if (mem_resp_valid) state_d = (count_d != '0) ? REQ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_valid    = (state_q == REQ);
    mem_req_instr    = mem_req_valid ? slot_q[0] : '0;
    mem_req_is_store = mem_req_valid && head_store;
  end

  // Retire stage: head word captured on the popping edge, presented one cycle later.
  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      retire_vld_p1   <= 1'b0;
      retire_instr_p1 <= '0;
    end else begin
      retire_vld_p1   <= pop;
      retire_instr_p1 <= pop ? slot_q[0] : '0;
    end
  end

  assign retire_valid = retire_vld_p1;
  assign retire_instr = retire_instr_p1;

`ifdef LSQ_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q;

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      stall_q <= '0;
    end else if (reset_sync) begin
      stall_q <= '0;
    end else if (disp_valid && !disp_ready) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_lsq_ctrl.sv
// Scoreboard bench for lsq_ctrl: expected retire words are queued at dispatch
// and a negedge monitor pops and compares them as the DUT retires.
module tb_lsq_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef LSQ_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd3;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic          clock = 1'b0;
  logic          reset_async;
  logic          reset_sync;
  logic          disp_valid;
  logic [31:0]   disp_instr;
  logic          disp_ready;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_instr;
  logic          mem_req_is_store;
  logic          mem_resp_valid;
  logic          retire_valid;
  logic [31:0]   retire_instr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [15:0]   stall_cnt;

  always #5 clock = ~clock;

  lsq_ctrl #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset_async      (reset_async),
    .reset_sync       (reset_sync),
    .disp_valid       (disp_valid),
    .disp_instr       (disp_instr),
    .disp_ready       (disp_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_instr    (mem_req_instr),
    .mem_req_is_store (mem_req_is_store),
    .mem_resp_valid   (mem_resp_valid),
    .retire_valid     (retire_valid),
    .retire_instr     (retire_instr),
    .count            (count),
    .empty            (empty),
    .full             (full),
    .stall_cnt        (stall_cnt)
  );

  int          checks    = 0;
  int          failures  = 0;
  int          n_retired = 0;
  bit          mon_en    = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (retire_valid === 1'b1) begin
        n_retired++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected actual=%0h required=no_retire", retire_instr);
        end else begin
          check("retire_instr", retire_instr, exp_q.pop_front());
        end
      end else begin
        check("retire_instr_idle", retire_instr, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] mixed [10];
  int          base;
  int          idx;
  bit          pend;
  bit          acc_load;
  bit          rdy;
  bit          done;

  initial begin
    mixed = '{32'h38000104, 32'h40000105, 32'h38000106, 32'h08000107, 32'h40000108,
              32'h38000109, 32'h3800010A, 32'h4000010B, 32'hF800010C, 32'h3800010D};
    reset_async    = 1'b1;
    reset_sync     = 1'b0;
    disp_valid     = 1'b0;
    disp_instr     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_async = 1'b0;
    mon_en      = 1'b1;

    check("rst_count",      count, 0);
    check("rst_empty",      empty, 1);
    check("rst_full",       full, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_req_valid",  mem_req_valid, 0);
    check("rst_req_instr",  mem_req_instr, 0);
    check("rst_retire",     retire_valid, 0);
    check("rst_stall",      stall_cnt, 0);

    // single store: two-cycle issue latency, then retire
    mem_req_ready = 1'b1;
    disp_valid    = 1'b1;
    disp_instr    = 32'h38000004;
    exp_q.push_back(32'h38000004);
    tick();
    disp_valid = 1'b0;
    disp_instr = '0;
    check("t1_count_pushed", count, 1);
    check("t1_req_early",    mem_req_valid, 0);
    tick();
    check("t1_req_valid", mem_req_valid, 1);
    check("t1_is_store",  mem_req_is_store, 1);
    check("t1_req_instr", mem_req_instr, 32'h38000004);
    tick();
    check("t1_count_after", count, 0);
    check("t1_req_idle",    mem_req_valid, 0);
    settle();
    check("t1_retired", n_retired, 1);

    // load waits for a delayed response
    disp_valid = 1'b1;
    disp_instr = 32'h40000008;
    exp_q.push_back(32'h40000008);
    tick();
    disp_valid = 1'b0;
    disp_instr = '0;
    tick();
    check("t2_req_valid", mem_req_valid, 1);
    check("t2_is_store",  mem_req_is_store, 0);
    tick();
    check("t2_wait_req", mem_req_valid, 0);
    base = n_retired;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_wait_count",   count, 1);
      check("t2_wait_req",     mem_req_valid, 0);
      check("t2_wait_noretire", n_retired, base);
    end
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("t2_count_after", count, 0);
    settle();
    check("t2_retired", n_retired, base + 1);

    // fill with stalled stores, refuse one more, then drain at one per cycle
    mem_req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp_valid = 1'b1;
      disp_instr = 32'h38000010 + i;
      exp_q.push_back(32'h38000010 + i);
      tick();
    end
    disp_instr = 32'h38000099;
    check("t3_full",       full, 1);
    check("t3_disp_ready", disp_ready, 0);
    check("t3_count",      count, DEPTH);
    repeat (3) tick();
    disp_valid = 1'b0;
    disp_instr = '0;
    check("t3_stall_cnt",     stall_cnt, EXP_STALL);
    check("t3_count_refused", count, DEPTH);
    base = n_retired;
    mem_req_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check("t3_drain_count", count, DEPTH - 1 - k);
    end
    settle();
    check("t3_drain_retired", n_retired, base + DEPTH);

    // same-cycle push and pop at count=3, then mixed traffic in FIFO order
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1'b1;
      disp_instr = 32'h38000101 + i;
      exp_q.push_back(32'h38000101 + i);
      tick();
    end
    disp_valid = 1'b0;
    check("t4_count_three", count, 3);
    mem_req_ready = 1'b1;
    idx  = 0;
    pend = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (idx < 10) begin
        disp_valid = 1'b1;
        disp_instr = mixed[idx];
      end else begin
        disp_valid = 1'b0;
        disp_instr = '0;
      end
      mem_resp_valid = pend;
      acc_load = mem_req_valid && mem_req_ready && !mem_req_is_store;
      rdy      = disp_ready;
      tick();
      if (disp_valid && rdy) begin
        exp_q.push_back(mixed[idx]);
        idx++;
      end
      pend = acc_load;
      if (cyc == 0) check("t4_count_push_pop", count, 3);
      if (idx == 10 && empty) done = 1'b1;
    end
    disp_valid     = 1'b0;
    disp_instr     = '0;
    mem_resp_valid = 1'b0;
    check("t4_done", done, 1);
    settle();
    check("t4_drained", exp_q.size(), 0);

    // flush while a load is outstanding; late response must be ignored
    base = n_retired;
    disp_valid = 1'b1;
    disp_instr = 32'h40000200;
    tick();
    disp_valid = 1'b0;
    tick();
    tick();
    check("t5_wait_req",   mem_req_valid, 0);
    check("t5_wait_count", count, 1);
    reset_sync = 1'b1;
    disp_valid = 1'b1;
    disp_instr = 32'h38000300;
    tick();
    reset_sync = 1'b0;
    disp_valid = 1'b0;
    disp_instr = '0;
    check("t5_flush_count", count, 0);
    check("t5_flush_empty", empty, 1);
    check("t5_flush_stall", stall_cnt, 0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("t5_late_count", count, 0);
    tick();
    check("t5_idle_req", mem_req_valid, 0);
    settle();
    check("t5_no_retire", n_retired, base);

    // zero word handshake is accepted and dropped
    disp_valid = 1'b1;
    disp_instr = 32'h0;
    check("t6_ready", disp_ready, 1);
    tick();
    disp_valid = 1'b0;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    tick();
    check("t6_no_issue", mem_req_valid, 0);
    tick();
    check("t6_no_issue_late", mem_req_valid, 0);
    settle();
    check("t6_no_retire", n_retired, base);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
